locw_arb: RTL and testbench
===========================

# locw_arb

Two-port round-robin arbiter and sequencer for the local-write path into the word-addressed RAM. It accepts byte-addressed writes from two local requesters over valid/ready handshakes and grants one per cycle. Each granted write is converted to a word address and issued through a single registered RAM write port that honours a stall input. It also keeps a write counter and a sticky misalignment flag for status readback.

## Interface
- LOC_AWIDTH, 32, byte-address width of requester and RAM address buses
- LOC_DWIDTH, 32, data width
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req0_vld  in  1  requester 0 write valid
- req0_rdy  out  1  requester 0 write accepted this cycle when high together with req0_vld
- req0_addr  in  LOC_AWIDTH  requester 0 byte address
- req0_data  in  LOC_DWIDTH  requester 0 write data
- req1_vld / req1_rdy / req1_addr / req1_data  same as requester 0, for requester 1
- ram_wr_en  out  1  RAM write strobe (registered)
- ram_wr_addr  out  LOC_AWIDTH  RAM word address, {2'b00, byte_addr[LOC_AWIDTH-1:2]}
- ram_wr_data  out  LOC_DWIDTH  RAM write data
- ram_wr_src  out  1  index of the requester that owns the current RAM write
- ram_stall  in  1  RAM cannot take a write this cycle; the output slot holds
- err_clr  in  1  clears err_misalign
- err_misalign  out  1  sticky: an accepted write had addr[1:0] != 0
- wr_cnt  out  16  count of RAM writes completed (ram_wr_en && !ram_stall), wraps at 16'hFFFF -> 0

## Operation
- Output slot free: slot_free = !ram_wr_en || !ram_stall.
- Arbitration pointer last (1 bit) records the last granted requester.
- Grant is combinational each cycle:
  - both valid: grant the requester != last;
  - one valid: grant that one;
  - none valid: no grant.
- reqN_rdy = grantN && slot_free. Ready depends only on vld inputs, last and slot state.
- Accept (reqN_vld && reqN_rdy) updates the slot on the next edge:
  - ram_wr_en <= 1;
  - ram_wr_addr <= word address;
  - ram_wr_data <= data;
  - ram_wr_src <= N;
  - last <= N.
- No accept and slot_free: ram_wr_en <= 0. Addr, data and src hold their last values.
- Stalled slot (ram_wr_en && ram_stall): all slot registers hold and both rdy are low. No write is dropped or duplicated.
- Misaligned accept: the write still issues with the address truncated to the word; err_misalign <= 1.
- err_clr on the same cycle as a misaligned accept: set wins, err_misalign = 1.
- wr_cnt increments by 1 on each cycle where ram_wr_en && !ram_stall. It is 16 bits, modulo 2^16.

## Timing
- Reset values: ram_wr_en=0, ram_wr_addr=0, ram_wr_data=0, ram_wr_src=0, err_misalign=0, wr_cnt=0, last=1. After reset, requester 0 wins the first tie.
- Latency: accept at edge k -> ram_wr_en high in cycle k+1.
- Throughput: one write per cycle with no stall. With both requesters continuously valid, grants alternate 0,1,0,1...
- Stall: a write held N cycles by ram_stall completes on the first cycle with ram_stall=0. A new accept can occur on that same cycle (back-to-back, no bubble).
- ram_stall while ram_wr_en=0 has no effect; the slot is free.
- Reset asserted mid-operation: a pending or stalled write is discarded; all state returns to reset values on that edge. rdy outputs are low while rst is high.
- Requester inputs must hold stable while vld=1 and rdy=0. The arbiter does not sample them until accept.

## Test plan
- Single write: req0 addr=32'h0000_0010, data=32'hDEAD_BEEF, one cycle -> next cycle ram_wr_en=1, ram_wr_addr=32'h0000_0004, ram_wr_data=32'hDEAD_BEEF, ram_wr_src=0; the cycle after, wr_cnt=1.
- Contention: both vld held 4 cycles, no stall -> grant order 0,1,0,1; four RAM writes on consecutive cycles, wr_cnt=4.
- Stall: write issued, ram_stall=1 for 3 cycles with req1_vld=1 -> req1_rdy=0 and RAM outputs unchanged for 3 cycles; req1 is accepted in the cycle ram_stall drops and issues the next cycle.
- Misalign: req1 addr=32'h0000_0013 -> ram_wr_addr=32'h0000_0004, err_misalign=1. err_clr pulse -> 0. Simultaneous misaligned accept and err_clr -> 1.
- Counter wrap: preload via 65535 writes, then one more -> wr_cnt=0.
- Reset mid-stall: rst during a stalled write -> ram_wr_en=0 and wr_cnt=0 next cycle; the next tie goes to requester 0.

Source files
------------

// File: rtl/locw_arb_if.sv
// Local-write bus bundle: two byte-addressed requesters in, one registered
// word-addressed RAM write port out.
interface locw_arb_if #(
   parameter int LOC_AWIDTH = 32,
   parameter int LOC_DWIDTH = 32
);
   logic                  req0_vld;
   logic                  req0_rdy;
   logic [LOC_AWIDTH-1:0] req0_addr;
   logic [LOC_DWIDTH-1:0] req0_data;
   logic                  req1_vld;
   logic                  req1_rdy;
   logic [LOC_AWIDTH-1:0] req1_addr;
   logic [LOC_DWIDTH-1:0] req1_data;
   logic                  ram_wr_en;
   logic [LOC_AWIDTH-1:0] ram_wr_addr;
   logic [LOC_DWIDTH-1:0] ram_wr_data;
   logic                  ram_wr_src;
   logic                  ram_stall;

   modport master (
      output req0_vld, req0_addr, req0_data,
      output req1_vld, req1_addr, req1_data,
      output ram_stall,
      input  req0_rdy, req1_rdy,
      input  ram_wr_en, ram_wr_addr, ram_wr_data, ram_wr_src
   );

   modport slave (
      input  req0_vld, req0_addr, req0_data,
      input  req1_vld, req1_addr, req1_data,
      input  ram_stall,
      output req0_rdy, req1_rdy,
      output ram_wr_en, ram_wr_addr, ram_wr_data, ram_wr_src
   );
endinterface

// File: rtl/locw_arb.sv
// Two-port round-robin arbiter feeding a single registered, stallable RAM
// write slot; keeps a completed-write counter and a sticky misalignment flag.
module locw_arb #(
   parameter int LOC_AWIDTH = 32,
   parameter int LOC_DWIDTH = 32
) (
   input  logic        clk,
   input  logic        rst,
   locw_arb_if.slave   bus,
   input  logic        err_clr,
   output logic        err_misalign,
   output logic [15:0] wr_cnt
);

   logic                  r_wr_en;
   logic [LOC_AWIDTH-1:0] r_wr_addr;
   logic [LOC_DWIDTH-1:0] r_wr_data;
   logic                  r_wr_src;
   logic                  r_last;
   logic                  r_err;
   logic [15:0]           r_cnt;

   logic                  w_slot_free;
   logic                  w_gnt0;
   logic                  w_gnt1;
   logic                  w_acc0;
   logic                  w_acc1;
   logic                  w_acc;
   logic                  w_misalign;
   logic [LOC_AWIDTH-1:0] w_sel_addr;
   logic [LOC_DWIDTH-1:0] w_sel_data;

   always_comb begin
      w_slot_free = !r_wr_en || !bus.ram_stall;
      // On a tie the requester that did not win last time gets the grant.
      w_gnt0      = bus.req0_vld && (!bus.req1_vld || r_last);
      w_gnt1      = bus.req1_vld && (!bus.req0_vld || !r_last);
      w_acc0      = w_gnt0 && w_slot_free && !rst;
      w_acc1      = w_gnt1 && w_slot_free && !rst;
      w_acc       = w_acc0 || w_acc1;
      w_sel_addr  = w_acc1 ? bus.req1_addr : bus.req0_addr;
      w_sel_data  = w_acc1 ? bus.req1_data : bus.req0_data;
      w_misalign  = w_acc && (w_sel_addr[1:0] != 2'b00);
      bus.req0_rdy = w_acc0;
      bus.req1_rdy = w_acc1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
         r_wr_src  <= 1'b0;
         r_last    <= 1'b1;
         r_err     <= 1'b0;
         r_cnt     <= '0;
      end else begin
         if (w_acc) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= {2'b00, w_sel_addr[LOC_AWIDTH-1:2]};
            r_wr_data <= w_sel_data;
            r_wr_src  <= w_acc1;
            r_last    <= w_acc1;
         end else if (w_slot_free) begin
            r_wr_en <= 1'b0;
         end
         if (r_wr_en && !bus.ram_stall) begin
            r_cnt <= r_cnt + 16'd1;
         end
         // A new misaligned accept outranks a simultaneous clear.
         if (w_misalign) begin
            r_err <= 1'b1;
         end else if (err_clr) begin
            r_err <= 1'b0;
         end
      end
   end

   assign bus.ram_wr_en   = r_wr_en;
   assign bus.ram_wr_addr = r_wr_addr;
   assign bus.ram_wr_data = r_wr_data;
   assign bus.ram_wr_src  = r_wr_src;
   assign err_misalign    = r_err;
   assign wr_cnt          = r_cnt;

endmodule

// File: tb/tb_locw_arb.sv
// Table-driven bench for locw_arb with a scoreboard of expected RAM writes,
// plus hand sequences for reset-during-stall and counter wrap.
module tb_locw_arb;

   logic        clk;
   logic        rst;
   logic        err_clr;
   logic        err_misalign;
   logic [15:0] wr_cnt;

   locw_arb_if #(.LOC_AWIDTH(32), .LOC_DWIDTH(32)) bus ();

   locw_arb #(.LOC_AWIDTH(32), .LOC_DWIDTH(32)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .err_clr      (err_clr),
      .err_misalign (err_misalign),
      .wr_cnt       (wr_cnt)
   );

   typedef struct {
      logic        v0;
      logic [31:0] a0;
      logic [31:0] d0;
      logic        v1;
      logic [31:0] a1;
      logic [31:0] d1;
      logic        st;
      logic        cl;
      logic        r0;
      logic        r1;
      logic        en;
      logic        er;
      logic [15:0] cnt;
   } vec_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic        src;
   } wr_t;

   vec_t vq[$];
   wr_t  exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic v0, input logic [31:0] a0, input logic [31:0] d0,
                               input logic v1, input logic [31:0] a1, input logic [31:0] d1,
                               input logic st, input logic cl,
                               input logic r0, input logic r1, input logic en, input logic er,
                               input logic [15:0] cnt);
      vec_t v;
      v.v0 = v0; v.a0 = a0; v.d0 = d0;
      v.v1 = v1; v.a1 = a1; v.d1 = d1;
      v.st = st; v.cl = cl;
      v.r0 = r0; v.r1 = r1; v.en = en; v.er = er; v.cnt = cnt;
      return v;
   endfunction

   function automatic wr_t mkw(input logic [31:0] byte_addr, input logic [31:0] data, input logic src);
      wr_t w;
      w.addr = byte_addr >> 2;
      w.data = data;
      w.src  = src;
      return w;
   endfunction

   task automatic drive(input logic v0, input logic [31:0] a0, input logic [31:0] d0,
                        input logic v1, input logic [31:0] a1, input logic [31:0] d1,
                        input logic st, input logic cl);
      bus.req0_vld  = v0;
      bus.req0_addr = a0;
      bus.req0_data = d0;
      bus.req1_vld  = v1;
      bus.req1_addr = a1;
      bus.req1_data = d1;
      bus.ram_stall = st;
      err_clr       = cl;
   endtask

   task automatic apply(input vec_t v, input int idx);
      drive(v.v0, v.a0, v.d0, v.v1, v.a1, v.d1, v.st, v.cl);
      @(negedge clk);
      chk($sformatf("v%0d_rdy0", idx), bus.req0_rdy, v.r0);
      chk($sformatf("v%0d_rdy1", idx), bus.req1_rdy, v.r1);
      chk($sformatf("v%0d_wr_en", idx), bus.ram_wr_en, v.en);
      chk($sformatf("v%0d_err", idx), err_misalign, v.er);
      chk($sformatf("v%0d_cnt", idx), wr_cnt, v.cnt);
      if (v.v0 && v.r0) exp_q.push_back(mkw(v.a0, v.d0, 1'b0));
      if (v.v1 && v.r1) exp_q.push_back(mkw(v.a1, v.d1, 1'b1));
      @(posedge clk); #1;
   endtask

   // Scoreboard: every completed RAM write must match the oldest expected write.
   always @(negedge clk) begin
      if (!rst && bus.ram_wr_en && !bus.ram_stall) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_wr", 32'd1, 32'd0);
         end else begin
            wr_t w;
            w = exp_q.pop_front();
            chk("wr_addr", bus.ram_wr_addr, w.addr);
            chk("wr_data", bus.ram_wr_data, w.data);
            chk("wr_src", bus.ram_wr_src, w.src);
         end
      end
   end

   initial begin
      int misses;
      drive(1'b1, 32'h0, 32'h0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_wr_en", bus.ram_wr_en, 32'd0);
      chk("rst_wr_addr", bus.ram_wr_addr, 32'd0);
      chk("rst_wr_data", bus.ram_wr_data, 32'd0);
      chk("rst_wr_src", bus.ram_wr_src, 32'd0);
      chk("rst_err", err_misalign, 32'd0);
      chk("rst_cnt", wr_cnt, 32'd0);
      chk("rst_rdy0", bus.req0_rdy, 32'd0);
      chk("rst_rdy1", bus.req1_rdy, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

      // single write, misaligned req1, contention, clear, stall, set-beats-clear
      vq.push_back(mk(1, 32'h10, 32'hDEADBEEF, 0, 0, 0,             0, 0, 1, 0, 0, 0, 0));
      vq.push_back(mk(0, 0, 0,                 0, 0, 0,             0, 0, 0, 0, 1, 0, 0));
      vq.push_back(mk(0, 0, 0,                 1, 32'h13, 32'h11111111, 0, 0, 0, 1, 0, 0, 1));
      vq.push_back(mk(1, 32'h20, 32'hA0,       1, 32'h24, 32'hB0,   0, 0, 1, 0, 1, 1, 1));
      vq.push_back(mk(1, 32'h28, 32'hA1,       1, 32'h24, 32'hB0,   0, 0, 0, 1, 1, 1, 2));
      vq.push_back(mk(1, 32'h28, 32'hA1,       1, 32'h2C, 32'hB1,   0, 0, 1, 0, 1, 1, 3));
      vq.push_back(mk(1, 32'h30, 32'hA2,       1, 32'h2C, 32'hB1,   0, 0, 0, 1, 1, 1, 4));
      vq.push_back(mk(0, 0, 0,                 0, 0, 0,             0, 1, 0, 0, 1, 1, 5));
      vq.push_back(mk(0, 0, 0,                 0, 0, 0,             0, 0, 0, 0, 0, 0, 6));
      vq.push_back(mk(1, 32'h40, 32'hC0,       0, 0, 0,             0, 0, 1, 0, 0, 0, 6));
      vq.push_back(mk(0, 0, 0,                 1, 32'h44, 32'hC1,   1, 0, 0, 0, 1, 0, 6));
      vq.push_back(mk(0, 0, 0,                 1, 32'h44, 32'hC1,   1, 0, 0, 0, 1, 0, 6));
      vq.push_back(mk(0, 0, 0,                 1, 32'h44, 32'hC1,   1, 0, 0, 0, 1, 0, 6));
      vq.push_back(mk(0, 0, 0,                 1, 32'h44, 32'hC1,   0, 0, 0, 1, 1, 0, 6));
      vq.push_back(mk(0, 0, 0,                 0, 0, 0,             0, 0, 0, 0, 1, 0, 7));
      vq.push_back(mk(1, 32'h50, 32'hD0,       0, 0, 0,             1, 0, 1, 0, 0, 0, 8));
      vq.push_back(mk(0, 0, 0,                 1, 32'h57, 32'hD1,   0, 1, 0, 1, 1, 0, 8));
      vq.push_back(mk(0, 0, 0,                 0, 0, 0,             0, 0, 0, 0, 1, 1, 9));
      vq.push_back(mk(0, 0, 0,                 0, 0, 0,             0, 0, 0, 0, 0, 1, 10));

      for (int i = 0; i < vq.size(); i++) begin
         apply(vq[i], i);
      end
      chk("tbl_q_empty", exp_q.size(), 32'd0);

      // reset while a write is stalled in the slot
      drive(1'b1, 32'h60, 32'hE0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      chk("rs_rdy0", bus.req0_rdy, 32'd1);
      exp_q.push_back(mkw(32'h60, 32'hE0, 1'b0));
      @(posedge clk); #1;
      drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      @(negedge clk);
      chk("rs_stalled_en", bus.ram_wr_en, 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk); #1;
      drive(1'b1, 32'h64, 32'hE1, 1'b1, 32'h68, 32'hE2, 1'b0, 1'b0);
      @(negedge clk);
      chk("rs_in_rst_rdy0", bus.req0_rdy, 32'd0);
      chk("rs_in_rst_rdy1", bus.req1_rdy, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      chk("rs_after_en", bus.ram_wr_en, 32'd0);
      chk("rs_after_cnt", wr_cnt, 32'd0);
      chk("rs_after_err", err_misalign, 32'd0);
      @(posedge clk); #1;
      drive(1'b1, 32'h70, 32'hF0, 1'b1, 32'h74, 32'hF1, 1'b0, 1'b0);
      @(negedge clk);
      chk("rs_tie_rdy0", bus.req0_rdy, 32'd1);
      chk("rs_tie_rdy1", bus.req1_rdy, 32'd0);
      exp_q.push_back(mkw(32'h70, 32'hF0, 1'b0));
      @(posedge clk); #1;
      drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      chk("rs_tie_wr_en", bus.ram_wr_en, 32'd1);
      @(posedge clk); #1;
      chk("rs_q_empty", exp_q.size(), 32'd0);

      // counter wrap: 65536 back-to-back writes from requester 0
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      misses = 0;
      for (int i = 0; i < 65536; i++) begin
         drive(1'b1, 32'(i) << 2, 32'(i) ^ 32'h5A5A0000, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
         @(negedge clk);
         if (bus.req0_rdy !== 1'b1) misses++;
         exp_q.push_back(mkw(32'(i) << 2, 32'(i) ^ 32'h5A5A0000, 1'b0));
         @(posedge clk); #1;
      end
      drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      chk("wrap_rdy_misses", misses, 32'd0);
      @(negedge clk);
      chk("wrap_cnt_ffff", wr_cnt, 32'h0000FFFF);
      @(posedge clk); #1;
      @(negedge clk);
      chk("wrap_cnt_zero", wr_cnt, 32'd0);
      chk("wrap_q_empty", exp_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
